// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array operand feeders.
package sa_pkg;

   // Feeder sequencing states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2
   } sa_feed_state_e;

   localparam int SA_DWIDTH = 8;   // default lane width
   localparam int SA_KLEN_W = 16;  // width of the tile-length field

endpackage

// File: rtl/sa_vec_fifo.sv
// Synchronous vector FIFO for the operand feeder. Occupancy is kept in a
// level register so full/empty/ready decisions all come straight off a flop.
// A push at full is refused even when a pop happens in the same cycle.
module sa_vec_fifo
   import sa_pkg::*;
#(
   parameter int ROWS   = 8,
   parameter int DWIDTH = SA_DWIDTH,
   parameter int DEPTH  = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int VW    = ROWS * DWIDTH
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          push,
   input  logic [VW-1:0] push_data,
   input  logic          pop,
   output logic [VW-1:0] pop_data,
   output logic [AW:0]   level
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [VW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic          w_push_ok;
   logic          w_pop_ok;

   assign w_push_ok = push && (r_level < FULL_LVL);
   assign w_pop_ok  = pop && (r_level != '0);
   assign pop_data  = r_mem[r_rd_ptr];
   assign level     = r_level;

   // Storage array; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
   end

   // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/sa_operand_feeder.sv
// Operand feeder for one edge of the systolic array: buffers packed vectors,
// replays a tile of k_len vectors as a diagonally skewed stream (lane i
// delayed by i advances), then flushes ROWS-1 zero vectors so every PE sees
// the whole tile. `fire` marks each cycle where out_data advanced.
// Optional build macro: SA_FEEDER_STALL_CNT_EN enables the empty-FIFO stall
// counter on stall_cnt; without it stall_cnt is tied to zero.
module sa_operand_feeder
   import sa_pkg::*;
#(
   parameter int ROWS   = 8,
   parameter int DWIDTH = SA_DWIDTH,
   parameter int DEPTH  = 16,
   localparam int LW    = $clog2(DEPTH) + 1,
   localparam int VW    = ROWS * DWIDTH
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [VW-1:0]        in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 start,
   input  logic [SA_KLEN_W-1:0] k_len,
   output logic                 busy,
   output logic                 done,
   output logic                 fire,
   output logic [VW-1:0]        out_data,
   output logic [LW-1:0]        fifo_level,
   output logic [15:0]          stall_cnt
);

   localparam int FW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   sa_feed_state_e               r_state;
   logic [SA_KLEN_W-1:0]         r_remaining;
   logic [FW-1:0]                r_flush_cnt;
   logic                         r_busy;
   logic                         r_done;
   logic                         r_last;   // last advance of the tile happened last cycle
   logic                         r_fire;
   logic [ROWS-1:0][DWIDTH-1:0]  r_out;

   logic [VW-1:0]                w_fifo_rd;
   logic                         w_empty;
   logic                         w_pop;
   logic                         w_adv;
   logic                         w_start_ok;
   logic [ROWS-1:0][DWIDTH-1:0]  w_skew_in;
   logic [ROWS-1:0][DWIDTH-1:0]  w_tap;

   sa_vec_fifo #(
      .ROWS   (ROWS),
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (in_valid),
      .push_data (in_data),
      .pop       (w_pop),
      .pop_data  (w_fifo_rd),
      .level     (fifo_level)
   );

   assign in_ready   = (fifo_level < FULL_LVL);
   assign w_empty    = (fifo_level == '0);
   assign w_pop      = (r_state == STREAM) && !w_empty;
   assign w_adv      = w_pop || (r_state == FLUSH);
   // busy also covers the cycle between the last advance and done
   assign w_start_ok = start && (r_state == IDLE) && !r_busy;
   assign w_skew_in  = (r_state == STREAM) ? w_fifo_rd : '0;

   // Per-lane delay lines: lane i holds i stages, shifting only on advance
   for (genvar gi = 0; gi < ROWS; gi++) begin : g_lane
      if (gi == 0) begin : g_direct
         assign w_tap[gi] = w_skew_in[gi];
      end else begin : g_delay
         logic [gi-1:0][DWIDTH-1:0] r_sh;
         // Shift the lane's delay line on every advance
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               r_sh <= '0;
            end else if (w_adv) begin
               r_sh[0] <= w_skew_in[gi];
               for (int j = 1; j < gi; j++) r_sh[j] <= r_sh[j-1];
            end
         end
         assign w_tap[gi] = r_sh[gi-1];
      end
   end

   // Common output register and fire strobe: update together on advance
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_out  <= '0;
         r_fire <= 1'b0;
      end else begin
         r_fire <= w_adv;
         if (w_adv) r_out <= w_tap;
      end
   end

   // Tile sequencer: IDLE -> STREAM (pop k_len vectors) -> FLUSH (ROWS-1 zeros)
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= IDLE;
         r_remaining <= '0;
         r_flush_cnt <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_last      <= 1'b0;
      end else begin
         r_done <= r_last;
         r_last <= 1'b0;
         if (r_last) r_busy <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start_ok) begin
                  if (k_len != '0) begin
                     r_remaining <= k_len;
                     r_state     <= STREAM;
                     r_busy      <= 1'b1;
                  end else begin
                     r_done <= 1'b1;   // empty tile: done without any fire
                  end
               end
            end
            STREAM: begin
               if (w_pop) begin
                  r_remaining <= r_remaining - SA_KLEN_W'(1);
                  if (r_remaining == SA_KLEN_W'(1)) begin
                     if (ROWS > 1) begin
                        r_state     <= FLUSH;
                        r_flush_cnt <= '0;
                     end else begin
                        r_state <= IDLE;
                        r_last  <= 1'b1;
                     end
                  end
               end
            end
            FLUSH: begin
               r_flush_cnt <= r_flush_cnt + FW'(1);
               if (r_flush_cnt == FW'(ROWS - 2)) begin
                  r_state <= IDLE;
                  r_last  <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign fire     = r_fire;
   assign out_data = r_out;

`ifdef SA_FEEDER_STALL_CNT_EN
   logic [15:0] r_stall;

   // Count STREAM cycles lost to an empty FIFO, saturating; cleared per tile
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_stall <= '0;
      end else if (w_start_ok) begin
         r_stall <= '0;
      end else if ((r_state == STREAM) && w_empty && (r_stall != 16'hFFFF)) begin
         r_stall <= r_stall + 16'd1;
      end
   end

   assign stall_cnt = r_stall;
`else
   assign stall_cnt = '0;
`endif

endmodule
